// File: rtl/conv_window_scheduler.sv
// Sequences one valid-mode 2-D convolution pass through a single shared MAC:
// fetches each window's taps from feature/weight RAMs, then biases, clamps and streams the result.
module conv_window_scheduler #(
    parameter int IN_BITS       = 8,
    parameter int OUT_BITS      = 32,
    parameter int IMG_W         = 8,
    parameter int IMG_H         = 8,
    parameter int KERNEL_SIZE_W = 3,
    parameter int KERNEL_SIZE_H = 3,
    parameter int RELU_EN       = 1,
    parameter int FEAT_AW       = $clog2(IMG_W * IMG_H),
    parameter int WGT_AW        = $clog2(KERNEL_SIZE_W * KERNEL_SIZE_H)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic signed [OUT_BITS-1:0] bias_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       feat_rd_o,
    output logic [FEAT_AW-1:0]         feat_addr_o,
    input  logic signed [IN_BITS-1:0]  feat_data_i,
    output logic                       wgt_rd_o,
    output logic [WGT_AW-1:0]          wgt_addr_o,
    input  logic signed [IN_BITS-1:0]  wgt_data_i,
    output logic                       mac_in_valid_o,
    output logic signed [IN_BITS-1:0]  mac_feature_o,
    output logic signed [IN_BITS-1:0]  mac_weight_o,
    input  logic                       mac_valid_i,
    input  logic signed [OUT_BITS-1:0] mac_data_i,
    output logic                       mac_ready_o,
    output logic                       out_valid_o,
    output logic signed [OUT_BITS-1:0] out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i
);

    localparam int OUT_W = IMG_W - KERNEL_SIZE_W + 1;
    localparam int OUT_H = IMG_H - KERNEL_SIZE_H + 1;
    localparam int RW    = $clog2(IMG_H + 1);
    localparam int CW    = $clog2(IMG_W + 1);
    localparam int KRW   = $clog2(KERNEL_SIZE_H + 1);
    localparam int KCW   = $clog2(KERNEL_SIZE_W + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MAC, OUTPUT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [RW-1:0]              r_q, r_d;
    logic [CW-1:0]              c_q, c_d;
    logic [KRW-1:0]             kr_q, kr_d;
    logic [KCW-1:0]             kc_q, kc_d;
    logic signed [OUT_BITS-1:0] bias_q, bias_d;
    logic signed [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic                       feat_rd_q, feat_rd_d;
    logic [FEAT_AW-1:0]         feat_addr_q, feat_addr_d;
    logic [WGT_AW-1:0]          wgt_addr_q, wgt_addr_d;
    logic                       mac_in_valid_q, mac_in_valid_d;
    logic                       mac_ready_q, mac_ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic signed [OUT_BITS-1:0] sum;
    logic                       last_win;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        bias_d      = bias_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        last_win    = (r_q == RW'(OUT_H - 1)) && (c_q == CW'(OUT_W - 1));
        sum         = mac_data_i + bias_q;
        if (RELU_EN != 0 && sum < 0) begin
            sum = '0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bias_d  = bias_i;
                    r_d     = '0;
                    c_d     = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (kc_q == KCW'(KERNEL_SIZE_W - 1)) begin
                    kc_d = '0;
                    if (kr_q == KRW'(KERNEL_SIZE_H - 1)) begin
                        kr_d    = '0;
                        state_d = WAIT_MAC;
                    end else begin
                        kr_d = kr_q + KRW'(1);
                    end
                end else begin
                    kc_d = kc_q + KCW'(1);
                end
            end
            WAIT_MAC: begin
                if (mac_valid_i) begin
                    out_data_d  = sum;
                    out_valid_d = 1'b1;
                    out_last_d  = last_win;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (last_win) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        if (c_q == CW'(OUT_W - 1)) begin
                            c_d = '0;
                            r_d = r_q + RW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        feat_rd_d      = (state_d == FETCH);
        feat_addr_d    = feat_rd_d ? FEAT_AW'((32'(r_d) + 32'(kr_d)) * IMG_W + 32'(c_d) + 32'(kc_d)) : '0;
        wgt_addr_d     = feat_rd_d ? WGT_AW'(32'(kr_d) * KERNEL_SIZE_W + 32'(kc_d)) : '0;
        mac_in_valid_d = feat_rd_q;
        mac_ready_d    = (state_d == WAIT_MAC);
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            r_q            <= '0;
            c_q            <= '0;
            kr_q           <= '0;
            kc_q           <= '0;
            bias_q         <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            feat_rd_q      <= 1'b0;
            feat_addr_q    <= '0;
            wgt_addr_q     <= '0;
            mac_in_valid_q <= 1'b0;
            mac_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            r_q            <= r_d;
            c_q            <= c_d;
            kr_q           <= kr_d;
            kc_q           <= kc_d;
            bias_q         <= bias_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            feat_rd_q      <= feat_rd_d;
            feat_addr_q    <= feat_addr_d;
            wgt_addr_q     <= wgt_addr_d;
            mac_in_valid_q <= mac_in_valid_d;
            mac_ready_q    <= mac_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // RAM read data arrives exactly one cycle after the enable, aligned with mac_in_valid_q.
    assign mac_feature_o  = mac_in_valid_q ? feat_data_i : '0;
    assign mac_weight_o   = mac_in_valid_q ? wgt_data_i : '0;
    assign mac_in_valid_o = mac_in_valid_q;
    assign feat_rd_o      = feat_rd_q;
    assign wgt_rd_o       = feat_rd_q;
    assign feat_addr_o    = feat_addr_q;
    assign wgt_addr_o     = wgt_addr_q;
    assign mac_ready_o    = mac_ready_q;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_last_o     = out_last_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler on a 4x4 map with a 3x3 kernel; instance 0 has ReLU off,
// instance 1 has ReLU on, both driven by the same stimulus, RAM contents and MAC behaviour.
module tb_conv_window_scheduler;

    localparam int T = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [31:0] bias_in;
    logic out_ready;

    logic busy [2], done [2], feat_rd [2], wgt_rd [2], mac_in_valid [2], mac_ready [2];
    logic out_valid [2], out_last [2];
    logic [3:0] feat_addr [2], wgt_addr [2];
    logic signed [7:0] mac_f [2], mac_w [2];
    logic signed [31:0] out_data [2];

    logic signed [7:0] feat_mem [16];
    logic signed [7:0] wgt_mem [9];
    int mac_lat;

    int n_checks = 0;
    int errs = 0;
    logic [3:0] fa_q[$];
    logic [3:0] wa_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic signed [7:0]  fd, wd;
        logic               mv, pend;
        logic signed [31:0] acc, res, prod;
        int                 cnt, dly;

        conv_window_scheduler #(
            .IN_BITS(8), .OUT_BITS(32), .IMG_W(4), .IMG_H(4),
            .KERNEL_SIZE_W(3), .KERNEL_SIZE_H(3), .RELU_EN(gi)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias_in),
            .busy_o(busy[gi]), .done_o(done[gi]),
            .feat_rd_o(feat_rd[gi]), .feat_addr_o(feat_addr[gi]), .feat_data_i(fd),
            .wgt_rd_o(wgt_rd[gi]), .wgt_addr_o(wgt_addr[gi]), .wgt_data_i(wd),
            .mac_in_valid_o(mac_in_valid[gi]), .mac_feature_o(mac_f[gi]), .mac_weight_o(mac_w[gi]),
            .mac_valid_i(mv), .mac_data_i(res), .mac_ready_o(mac_ready[gi]),
            .out_valid_o(out_valid[gi]), .out_data_o(out_data[gi]), .out_last_o(out_last[gi]),
            .out_ready_i(out_ready)
        );

        always @(posedge clk) begin
            if (feat_rd[gi]) fd <= feat_mem[feat_addr[gi]];
            if (wgt_rd[gi])  wd <= wgt_mem[wgt_addr[gi]];
        end

        // Behavioural MAC: sums T products, then presents the result after mac_lat cycles
        assign prod = 32'(mac_f[gi]) * 32'(mac_w[gi]);
        always @(posedge clk) begin
            if (!rst_n) begin
                acc <= 0; res <= 0; cnt <= 0; dly <= 0; pend <= 1'b0; mv <= 1'b0;
            end else begin
                if (mac_in_valid[gi]) begin
                    if (cnt == T - 1) begin
                        res <= acc + prod; acc <= 0; cnt <= 0; pend <= 1'b1; dly <= mac_lat;
                    end else begin
                        acc <= acc + prod; cnt <= cnt + 1;
                    end
                end
                if (pend) begin
                    if (dly <= 1) begin mv <= 1'b1; pend <= 1'b0; end
                    else dly <= dly - 1;
                end
                if (mv && mac_ready[gi]) mv <= 1'b0;
            end
        end
    end

    typedef struct {
        int bias;
        int rdy;
        int lat;
        int mid;
        logic [3:0][31:0] e0;
        logic [3:0][31:0] e1;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] pk(input int a, input int b, input int c, input int d);
        logic [3:0][31:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    // Reference: direct sum of products over each valid window, plus bias, optional clamp.
    function automatic logic [3:0][31:0] ref_pass(input int bias, input bit relu);
        logic [3:0][31:0] v;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                int s;
                s = bias;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        s += int'(feat_mem[(r + kr) * 4 + c + kc]) * int'(wgt_mem[kr * 3 + kc]);
                if (relu && s < 0) s = 0;
                v[r * 2 + c] = s;
            end
        end
        return v;
    endfunction

    function automatic int nonzero_outs(input int i);
        return {busy[i], done[i], feat_rd[i], wgt_rd[i], mac_in_valid[i], mac_ready[i],
                out_valid[i], out_last[i], feat_addr[i] != 0, wgt_addr[i] != 0,
                out_data[i] != 0, mac_f[i] != 0, mac_w[i] != 0};
    endfunction

    task automatic run_pass(input int bias, input int ready_pct, input int mid_start,
                            input logic [3:0][31:0] e0, input logic [3:0][31:0] e1, input string tag);
        int got[2];
        int dn[2];
        int cyc, run, nruns, runs_bad;
        bit ok;
        logic [31:0] ev;
        got = '{0, 0}; dn = '{0, 0};
        cyc = 0; run = 0; nruns = 0; runs_bad = 0;
        fa_q.delete(); wa_q.delete();
        @(posedge clk); #1;
        start = 1'b1; bias_in = bias;
        @(posedge clk); #1;
        start = 1'b0;
        while (dn[0] == 0 && cyc < 3000) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            start = (mid_start != 0 && cyc == mid_start);
            if (start) bias_in = 32'h1234_5678;
            @(negedge clk);
            if (feat_rd[0]) begin fa_q.push_back(feat_addr[0]); wa_q.push_back(wgt_addr[0]); end
            if (mac_in_valid[0]) run++;
            else if (run != 0) begin nruns++; if (run != T) runs_bad++; run = 0; end
            for (int i = 0; i < 2; i++) begin
                if (out_valid[i] && out_ready) begin
                    if (got[i] < 4) begin
                        ev = (i == 0) ? e0[got[i]] : e1[got[i]];
                        chk(out_data[i] == ev, $sformatf("%s_i%0d_w%0d_data", tag, i, got[i]),
                            out_data[i], $signed(ev));
                        chk(out_last[i] == (got[i] == 3), $sformatf("%s_i%0d_w%0d_last", tag, i, got[i]),
                            out_last[i], got[i] == 3);
                    end else begin
                        chk(1'b0, $sformatf("%s_i%0d_extra_result", tag, i), got[i] + 1, 4);
                    end
                    got[i]++;
                end
                if (done[i]) dn[i]++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk(cyc < 3000, {tag, "_timeout"}, cyc, 3000);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (done[i]) dn[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            chk(got[i] == 4, $sformatf("%s_i%0d_count", tag, i), got[i], 4);
            chk(dn[i] == 1, $sformatf("%s_i%0d_done_pulses", tag, i), dn[i], 1);
            chk(busy[i] == 1'b0, $sformatf("%s_i%0d_busy_after", tag, i), busy[i], 0);
        end
        ok = (fa_q.size() == 4 * T);
        if (ok) begin
            for (int w = 0; w < 4; w++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        if (fa_q[w * T + kr * 3 + kc] != 4'((w / 2 + kr) * 4 + (w % 2) + kc) ||
                            wa_q[w * T + kr * 3 + kc] != 4'(kr * 3 + kc)) ok = 1'b0;
        end
        chk(ok, {tag, "_addr_trace"}, fa_q.size(), 4 * T);
        chk(nruns == 4 && runs_bad == 0, {tag, "_mac_runs"}, nruns * 100 + runs_bad, 400);
        @(posedge clk); #1;
    endtask

    initial begin
        int w11[9];
        int hs;
        int b;
        bit seen;
        logic [3:0][31:0] r0, r1;
        w11 = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        rst_n = 1'b0; start = 1'b0; bias_in = 0; out_ready = 1'b1; mac_lat = 1;
        for (int i = 0; i < 16; i++) feat_mem[i] = 8'(i + 1);
        for (int i = 0; i < 9; i++) wgt_mem[i] = 8'sd1;

        vecs[0] = '{bias: 0,    rdy: 100, lat: 1, mid: 0,  e0: pk(54, 63, 90, 99),    e1: pk(54, 63, 90, 99)};
        vecs[1] = '{bias: -100, rdy: 100, lat: 2, mid: 0,  e0: pk(-46, -37, -10, -1), e1: pk(0, 0, 0, 0)};
        vecs[2] = '{bias: 7,    rdy: 60,  lat: 3, mid: 20, e0: pk(61, 70, 97, 106),   e1: pk(61, 70, 97, 106)};
        vecs[3] = '{bias: -60,  rdy: 40,  lat: 1, mid: 0,  e0: pk(-6, 3, 30, 39),     e1: pk(0, 3, 30, 39)};
        vecs[4] = '{bias: 0,    rdy: 100, lat: 4, mid: 35, e0: pk(54, 63, 90, 99),    e1: pk(54, 63, 90, 99)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk(nonzero_outs(i) == 0, $sformatf("reset_outputs_i%0d", i), nonzero_outs(i), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            mac_lat = vecs[v].lat;
            run_pass(vecs[v].bias, vecs[v].rdy, vecs[v].mid, vecs[v].e0, vecs[v].e1, $sformatf("vec%0d", v));
            if (v == 0) begin
                for (int k = 0; k < T; k++) begin
                    chk(fa_q.size() == 4 * T && fa_q[3 * T + k] == 4'(w11[k]), $sformatf("win11_feat_addr%0d", k),
                        fa_q.size() == 4 * T ? fa_q[3 * T + k] : 99, w11[k]);
                    chk(fa_q.size() == 4 * T && wa_q[3 * T + k] == 4'(k), $sformatf("win11_wgt_addr%0d", k),
                        fa_q.size() == 4 * T ? wa_q[3 * T + k] : 99, k);
                end
            end
        end

        // Backpressure on window 0: result must hold and no fetch may start.
        mac_lat = 2; out_ready = 1'b0;
        start = 1'b1; bias_in = 0;
        @(posedge clk); #1; start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid[0];
        end
        chk(seen, "stall_valid_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
            chk(out_valid[0] == 1'b1, $sformatf("stall_valid_c%0d", k), out_valid[0], 1);
            chk(out_data[0] == 54, $sformatf("stall_data_c%0d", k), out_data[0], 54);
            chk(feat_rd[0] == 1'b0, $sformatf("stall_no_fetch_c%0d", k), feat_rd[0], 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk(feat_rd[0] == 1'b1, "release_fetch_next_cycle", feat_rd[0], 1);
        chk(out_valid[0] == 1'b0, "release_valid_drop", out_valid[0], 0);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = done[0];
        end
        chk(seen, "stall_pass_done", seen, 1);

        // Reset during the fetch of window 2, then a clean pass.
        @(posedge clk); #1;
        start = 1'b1; bias_in = 0;
        @(posedge clk); #1; start = 1'b0;
        hs = 0; seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (hs == 2 && feat_rd[0]) seen = 1'b1;
            if (out_valid[0] && out_ready) hs++;
        end
        chk(seen, "rst_reach_window2", hs, 2);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk(nonzero_outs(i) == 0, $sformatf("midpass_rst_outputs_i%0d", i), nonzero_outs(i), 0);
        rst_n = 1'b1;
        run_pass(0, 100, 0, vecs[0].e0, vecs[0].e1, "after_rst");

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) feat_mem[i] = 8'($urandom);
            for (int i = 0; i < 9; i++) wgt_mem[i] = 8'($urandom);
            b = (k % 2 == 1) ? int'($urandom) : int'($urandom_range(0, 40000)) - 20000;
            mac_lat = int'($urandom_range(1, 4));
            r0 = ref_pass(b, 1'b0);
            r1 = ref_pass(b, 1'b1);
            run_pass(b, int'($urandom_range(30, 100)), 0, r0, r1, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errs, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
